dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the single-port, synchronous-read data memory between the CPU pipeline's MEM stage and an external debug/loader port. It lets the bench or a host program memory while the CPU runs, and removes the need to poke `dataMem.memory` hierarchically. The block sits between the MEM stage and `dataMem`. It drives a stall into the hazard path whenever a CPU access cannot finish in the current cycle.

## Interface
Parameters:
- `ADDR_W`, 8: memory address width.
- `DATA_W`, 8: data width.
- `DBG_MAX_WAIT`, 4: cycles a pending debug request may lose before it is forced through. Used only with `DMEM_ARB_STARVE_EN`. Legal range 1..15.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: MEM stage has a load or store. Held stable, with its qualifiers, while `cpu_stall`=1.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in `ADDR_W`: CPU access address.
- `cpu_wdata` in `DATA_W`: CPU store data.
- `cpu_rdata` out `DATA_W`: load data, valid in the cycle `cpu_stall` falls after a load.
- `cpu_stall` out 1: freeze the pipeline this cycle.
- `dbg_req` in 1: debug access request. Held, with its qualifiers, until `dbg_gnt`.
- `dbg_we` in 1: 1 = write, 0 = read.
- `dbg_addr` in `ADDR_W`: debug access address.
- `dbg_wdata` in `DATA_W`: debug write data.
- `dbg_gnt` out 1: one-cycle pulse; the access issues this cycle.
- `dbg_rvalid` out 1: one-cycle pulse marking read data on `dbg_rdata`.
- `dbg_rdata` out `DATA_W`: debug read data, meaningful only with `dbg_rvalid`.
- `mem_en` out 1: memory access enable.
- `mem_we` out 1: memory write enable.
- `mem_addr` out `ADDR_W`: memory address.
- `mem_wdata` out `DATA_W`: memory write data.
- `mem_rdata` in `DATA_W`: memory read data, one cycle after `mem_en` with `mem_we`=0.

## Operation
- FSM states:
  - `S_IDLE`: the only state in which an access issues.
  - `S_CPU_RD`: returning CPU load data.
  - `S_DBG_RD`: returning debug read data.
- Arbitration in `S_IDLE`:
  - CPU has fixed priority.
  - Debug wins only if `cpu_req`=0, or if the starve counter has saturated (see Configuration).
- Issue in `S_IDLE`:
  - The winner's `we`, `addr` and `wdata` are muxed onto the `mem_*` outputs with `mem_en`=1.
  - Writes complete in that cycle; the FSM stays in `S_IDLE`.
  - A read moves the FSM to `S_CPU_RD` or `S_DBG_RD`.
- Read return:
  - `S_CPU_RD`: `cpu_rdata` = `mem_rdata` combinationally, `cpu_stall`=0, nothing issues.
  - `S_DBG_RD`: `dbg_rdata` = `mem_rdata`, `dbg_rvalid`=1, nothing issues.
  - Both states return to `S_IDLE` unconditionally.
- `cpu_stall` is combinational and equals 1 when either holds:
  - `cpu_req`=1 in `S_IDLE` and the CPU wins with a load, or the CPU loses arbitration.
  - `cpu_req`=1 in `S_DBG_RD`.
- `cpu_stall` is 0 in every other case, including a granted store and all of `S_CPU_RD`.
- `cpu_req` still high in `S_CPU_RD` is the same, consumed load. It is never re-issued.
- `dbg_rdata` and `cpu_rdata` are don't-care outside their valid cycles.
- Reset:
  - State goes to `S_IDLE` and the starve counter clears.
  - An in-flight read is dropped: no `dbg_rvalid`, and no CPU data is delivered.
- Outputs during reset and in `S_IDLE` with no request: `mem_en`, `mem_we`, `dbg_gnt`, `dbg_rvalid` and `cpu_stall` are 0. `mem_addr` and `mem_wdata` are 0.

## Timing
- CPU store: issued and completed in cycle N, 0 stall cycles.
- CPU load: issued in N with stall=1; data and stall=0 in N+1; the next access can issue in N+2.
- Debug write: `dbg_gnt` in cycle N.
- Debug read: `dbg_gnt` in N, `dbg_rvalid` in N+1.
- Back-to-back debug reads: one every 2 cycles.
- Simultaneous CPU and debug request in `S_IDLE`: the CPU is issued. Debug waits, with `dbg_gnt`=0.
- A CPU request arriving during `S_DBG_RD` stalls one cycle, then issues in the following `S_IDLE`.

## Configuration
Macro: `DMEM_ARB_STARVE_EN`.

With the macro defined:
- A 4-bit starve counter increments each cycle that `dbg_req`=1 in `S_IDLE` and debug is not granted.
- When the counter equals `DBG_MAX_WAIT`, debug wins the next `S_IDLE` arbitration even against `cpu_req`. The CPU stalls that cycle.
- The counter clears on `dbg_gnt`, and whenever `dbg_req`=0.
- The counter holds in the read states.

Without the macro:
- Strict CPU priority; debug can starve indefinitely.
- No counter logic.

## Structure
- Shared package `dmem_arb_pkg` holds:
  - the state enum `dmem_arb_state_t` (`S_IDLE`, `S_CPU_RD`, `S_DBG_RD`);
  - the requester enum `arb_src_t` (`SRC_CPU`, `SRC_DBG`);
  - the starve counter width constant `STARVE_CNT_W` = 4.
- Sub-module `dmem_arb_starve_cnt` holds the counter and its saturate compare. It is instantiated only under `DMEM_ARB_STARVE_EN`.

## Test plan
- Reset, then CPU store to address 0x00 of data 0x02 -> `mem_en`=1 and `mem_we`=1 in the same cycle, `cpu_stall`=0, memory location 0x00 = 0x02.
- CPU load from 0x00 -> `cpu_stall`=1 in the issue cycle; next cycle `cpu_rdata`=0x02 with `cpu_stall`=0; no second `mem_en` in that cycle.
- Debug write 0xFF to 0x10, then debug read of 0x10 with CPU idle -> `dbg_gnt` on each; `dbg_rvalid` with `dbg_rdata`=0xFF one cycle after the read grant.
- `cpu_req` and `dbg_req` raised together -> the CPU is issued first; debug is granted in the first `S_IDLE` cycle with `cpu_req`=0.
- With `DMEM_ARB_STARVE_EN`, `DBG_MAX_WAIT`=4 and continuous CPU stores, assert `dbg_req` -> `dbg_gnt` on the 5th `S_IDLE` cycle, `cpu_stall`=1 in that cycle, counter back to 0 afterwards. Without the macro -> no `dbg_gnt` over 20 cycles.
- Debug read granted, then `reset` asserted in the `S_DBG_RD` cycle -> `dbg_rvalid` stays 0; all outputs 0 on the next cycle; state `S_IDLE`.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CPU_RD, S_DBG_RD} dmem_arb_state_t;
  typedef enum logic {SRC_CPU, SRC_DBG} arb_src_t;
  localparam int STARVE_CNT_W = 4;
endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// dmem_arb_starve_cnt: counts lost debug arbitrations and flags when debug must be forced through.
module dmem_arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int DBG_MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic lose_i,
  input  logic clr_i,
  output logic sat_o
);
  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : lose_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign sat_o = cnt_q == STARVE_CNT_W'(DBG_MAX_WAIT);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the CPU MEM stage and a debug port.
// Optional anti-starvation for debug is enabled by defining DMEM_ARB_STARVE_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int DBG_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  dmem_arb_state_t state_q, state_d;
  arb_src_t src;
  logic idle, starve_sat, dbg_win, issue, win_we, en;
  always_comb begin
    idle    = state_q == S_IDLE;
    dbg_win = dbg_req && (!cpu_req || starve_sat);
    src     = dbg_win ? SRC_DBG : SRC_CPU;
    issue   = idle && (cpu_req || dbg_req);
    win_we  = (src == SRC_DBG) ? dbg_we : cpu_we;
  end
`ifdef DMEM_ARB_STARVE_EN
  dmem_arb_starve_cnt #(.DBG_MAX_WAIT(DBG_MAX_WAIT)) u_starve (
    .clk   (clk),
    .reset (reset),
    .lose_i(dbg_req && idle && !dbg_win),
    .clr_i (!dbg_req || (idle && dbg_win)),
    .sat_o (starve_sat)
  );
`else
  assign starve_sat = 1'b0 && (DBG_MAX_WAIT != 0);
`endif
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb
    state_d = (issue && !win_we) ? ((src == SRC_DBG) ? S_DBG_RD : S_CPU_RD) : S_IDLE;
  // Everything is gated by reset so an in-flight read is silently dropped.
  always_comb begin
    en         = !reset && issue;
    mem_en     = en;
    mem_we     = en && win_we;
    mem_addr   = !en ? '0 : (src == SRC_DBG) ? dbg_addr : cpu_addr;
    mem_wdata  = !en ? '0 : (src == SRC_DBG) ? dbg_wdata : cpu_wdata;
    dbg_gnt    = !reset && idle && dbg_win;
    dbg_rvalid = !reset && state_q == S_DBG_RD;
    cpu_stall  = !reset && cpu_req && (idle ? (dbg_win || !cpu_we) : state_q == S_DBG_RD);
    cpu_rdata  = mem_rdata;
    dbg_rdata  = mem_rdata;
  end
endmodule
